// File: rtl/clock_enable_gen_pkg.sv
// Shared defaults, legal parameter ranges and helpers for the clock enable generator.
`ifndef CLOCK_ENABLE_GEN_PKG_SV
`define CLOCK_ENABLE_GEN_PKG_SV

// Selects channel i's divisor field out of the packed div_in bus.
`define CEG_DIV_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package clock_enable_gen_pkg;

  localparam int NCH_DEF         = 2;
  localparam int NCH_MIN         = 1;
  localparam int NCH_MAX         = 8;
  localparam int WIDTH_DEF       = 18;
  localparam int WIDTH_MIN       = 2;
  localparam int WIDTH_MAX       = 32;
  localparam int DEFAULT_DIV_DEF = 4;
  localparam int DEFAULT_DIV_MIN = 1;

  // A divisor of zero would never wrap, so it is treated as one.
  function automatic logic [31:0] eff_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

`endif

// File: rtl/clock_enable_gen_chan.sv
// One divider channel: counter, registered tick/square outputs and a
// pending-divisor slot that is adopted only at a period boundary.
module clock_enable_chan
  import clock_enable_gen_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             sq,
  output logic             div_ack
);

  logic [WIDTH-1:0] div_act;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;
  logic             pend_flag;
  logic             wrap;
  logic             adopt;

  // div_act is never zero (clamped on adoption), so div_act-1 cannot underflow.
  assign wrap  = en && (cnt == div_act - WIDTH'(1));
  assign adopt = pend_flag && (wrap || !en);

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt       <= '0;
      div_act   <= WIDTH'(DEFAULT_DIV);
      pend      <= '0;
      pend_flag <= 1'b0;
      tick      <= 1'b0;
      sq        <= 1'b0;
      div_ack   <= 1'b0;
    end else begin
      tick    <= wrap;
      div_ack <= adopt;
      if (wrap)
        sq <= ~sq;

      if (adopt) begin
        div_act <= WIDTH'(eff_div(32'(pend)));
        cnt     <= '0;
      end else if (wrap) begin
        cnt <= '0;
      end else if (en) begin
        cnt <= cnt + WIDTH'(1);
      end

      // A load arriving on an adoption cycle becomes the next pending value.
      if (div_load) begin
        pend      <= div_in;
        pend_flag <= 1'b1;
      end else if (adopt) begin
        pend_flag <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/clock_enable_gen.sv
// Array of NCH independent clock-enable divider channels sharing one clock.
module clock_enable_gen
  import clock_enable_gen_pkg::*;
#(
  parameter int NCH         = NCH_DEF,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [NCH-1:0]       en,
  input  logic [NCH*WIDTH-1:0] div_in,
  input  logic [NCH-1:0]       div_load,
  output logic [NCH-1:0]       tick,
  output logic [NCH-1:0]       sq,
  output logic [NCH-1:0]       div_ack
);

  if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
    $error("clock_enable_gen: NCH out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("clock_enable_gen: WIDTH out of range");
  end
  if (DEFAULT_DIV < DEFAULT_DIV_MIN ||
      longint'(DEFAULT_DIV) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_div
    $error("clock_enable_gen: DEFAULT_DIV out of range");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    clock_enable_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .clr      (clr),
      .en       (en[i]),
      .div_in   (`CEG_DIV_SLICE(div_in, i, WIDTH)),
      .div_load (div_load[i]),
      .tick     (tick[i]),
      .sq       (sq[i]),
      .div_ack  (div_ack[i])
    );
  end

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen (NCH=2, WIDTH=18, DEFAULT_DIV=4).
module tb_clock_enable_gen;

  localparam int NCH   = 2;
  localparam int WIDTH = 18;

  logic                 clk;
  logic                 clr;
  logic [NCH-1:0]       en;
  logic [NCH*WIDTH-1:0] div_in;
  logic [NCH-1:0]       div_load;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       sq;
  logic [NCH-1:0]       div_ack;

  int             checks   = 0;
  int             failures = 0;
  logic [NCH-1:0] exp_sq   = '0;

  clock_enable_gen #(
    .NCH         (NCH),
    .WIDTH       (WIDTH),
    .DEFAULT_DIV (4)
  ) dut (
    .clk      (clk),
    .clr      (clr),
    .en       (en),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .sq       (sq),
    .div_ack  (div_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic c, input logic [1:0] e, input logic [1:0] ld,
                               input int d0, input int d1);
    clr                 = c;
    en                  = e;
    div_load            = ld;
    div_in[0 +: WIDTH]     = WIDTH'(d0);
    div_in[WIDTH +: WIDTH] = WIDTH'(d1);
  endtask

  task automatic checkOutput(input string tag, input logic [1:0] et,
                             input logic [1:0] es, input logic [1:0] ea);
    checks++;
    assert (tick === et) else begin
      failures++;
      $error("[TB] FAIL %s tick observed=%b expected=%b", tag, tick, et);
    end
    checks++;
    assert (sq === es) else begin
      failures++;
      $error("[TB] FAIL %s sq observed=%b expected=%b", tag, sq, es);
    end
    checks++;
    assert (div_ack === ea) else begin
      failures++;
      $error("[TB] FAIL %s div_ack observed=%b expected=%b", tag, div_ack, ea);
    end
  endtask

  // One clock, then compare; sq is expected to toggle wherever a tick is expected.
  task automatic stepCheck(input string tag, input logic [1:0] et, input logic [1:0] ea);
    @(posedge clk);
    #1;
    exp_sq = exp_sq ^ et;
    checkOutput(tag, et, exp_sq, ea);
  endtask

  initial begin
    applyStimulus(1'b1, 2'b00, 2'b00, 0, 0);
    @(posedge clk);
    #1;
    exp_sq = 2'b00;
    checkOutput("reset", 2'b00, 2'b00, 2'b00);

    // ch0 runs at the default divisor; ch1 idle adopts a 5 while disabled
    applyStimulus(1'b0, 2'b01, 2'b10, 0, 5);
    stepCheck("div4_k1", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    for (int k = 2; k <= 12; k++)
      stepCheck("div4", {1'b0, (k % 4) == 0}, {k == 2, 1'b0});

    // enable dropped with cnt at 2 for five cycles
    stepCheck("hold_c1", 2'b00, 2'b00);
    stepCheck("hold_c2", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b00, 2'b00, 0, 0);
    for (int k = 0; k < 5; k++)
      stepCheck("hold_off", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    stepCheck("hold_c3", 2'b00, 2'b00);
    stepCheck("hold_wrap", 2'b01, 2'b00);
    for (int k = 1; k <= 4; k++)
      stepCheck("hold_after", {1'b0, k == 4}, 2'b00);

    // load 3 mid-period: old period finishes, then period 3
    stepCheck("ld3_c1", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 3, 0);
    stepCheck("ld3_cap", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    stepCheck("ld3_c3", 2'b00, 2'b00);
    stepCheck("ld3_adopt", 2'b01, 2'b01);
    for (int j = 1; j <= 6; j++)
      stepCheck("div3", {1'b0, (j % 3) == 0}, 2'b00);

    // load 6 coincident with a wrap: one more period of 3, then adopt
    stepCheck("ld6_c1", 2'b00, 2'b00);
    stepCheck("ld6_c2", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 6, 0);
    stepCheck("ld6_onwrap", 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    stepCheck("ld6_c1b", 2'b00, 2'b00);
    stepCheck("ld6_c2b", 2'b00, 2'b00);
    stepCheck("ld6_adopt", 2'b01, 2'b01);
    for (int j = 1; j <= 12; j++)
      stepCheck("div6", {1'b0, (j % 6) == 0}, 2'b00);

    // divisor 0 behaves as 1, then an explicit 1
    applyStimulus(1'b0, 2'b01, 2'b01, 0, 0);
    stepCheck("ld0_cap", 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    for (int j = 0; j < 4; j++)
      stepCheck("ld0_wait", 2'b00, 2'b00);
    stepCheck("ld0_adopt", 2'b01, 2'b01);
    for (int j = 0; j < 4; j++)
      stepCheck("div1", 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b01, 1, 0);
    stepCheck("ld1_cap", 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    stepCheck("ld1_adopt", 2'b01, 2'b01);
    stepCheck("div1b", 2'b01, 2'b00);
    stepCheck("div1b", 2'b01, 2'b00);

    // ch0 to 2, ch1 (already 5) enabled: independent rates
    applyStimulus(1'b0, 2'b01, 2'b01, 2, 0);
    stepCheck("ld2_cap", 2'b01, 2'b00);
    applyStimulus(1'b0, 2'b01, 2'b00, 0, 0);
    stepCheck("ld2_adopt", 2'b01, 2'b01);
    applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
    for (int h = 1; h <= 7; h++)
      stepCheck("dual", {(h % 5) == 0, (h % 2) == 0}, 2'b00);

    // reset mid-period with a competing load that must be discarded
    applyStimulus(1'b1, 2'b11, 2'b11, 7, 7);
    @(posedge clk);
    #1;
    exp_sq = 2'b00;
    checkOutput("clr_mid", 2'b00, 2'b00, 2'b00);
    applyStimulus(1'b0, 2'b11, 2'b00, 0, 0);
    for (int k = 1; k <= 8; k++)
      stepCheck("post_clr", {(k % 4) == 0, (k % 4) == 0}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
